// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator processor.
// Moore outputs decoded from the state register and the opcode/register field latched in DECODE.
module control_sequencer #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        z_flag,
  output logic [3:0]  read_en,
  output logic [10:0] write_en,
  output logic [1:0]  alu_op,
  output logic        pc_inc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_JPNZ = 4'h7;
  localparam logic [3:0] OP_LDIM = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] SRC_PC = 4'd1;
  localparam logic [3:0] SRC_AC = 4'd5;
  localparam logic [3:0] SRC_R  = 4'd6;
  localparam logic [3:0] SRC_DM = 4'd12;
  localparam logic [3:0] SRC_IM = 4'd13;

  state_t     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic [2:0] n_q, n_d;

  // Only the opcode and register field of the instruction are decoded here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[11:3];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH1;
      opcode_q <= '0;
      n_q      <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      n_q      <= n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    n_d      = n_q;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = ir[15:12];
        n_d      = ir[2:0];
        case (ir[15:12])
          OP_NOP:  state_d = S_FETCH1;
          OP_HALT: state_d = S_HALT;
          4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE:
            state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH1;
          default: state_d = S_EXEC1;
        endcase
      end
      S_EXEC1: begin
        if (opcode_q == OP_LDAC || opcode_q == OP_JPNZ || opcode_q == OP_LDIM)
          state_d = S_EXEC2;
        else
          state_d = S_FETCH1;
      end
      S_EXEC2: state_d = S_FETCH1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH1;
    endcase
  end

  // Outputs are forced low while reset is asserted so an aborted instruction issues no strobe.
  always_comb begin
    read_en  = '0;
    write_en = '0;
    alu_op   = '0;
    pc_inc   = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH2: begin
          read_en     = SRC_IM;
          write_en[2] = 1'b1;
          pc_inc      = 1'b1;
        end
        S_EXEC1: begin
          case (opcode_q)
            OP_STAC: begin
              read_en      = SRC_AC;
              write_en[10] = 1'b1;
            end
            OP_MVAC: begin
              read_en = SRC_AC;
              if (n_q < 3'd6) write_en[4'd4 + {1'b0, n_q}] = 1'b1;
            end
            OP_MOVR, OP_ADD, OP_SUB: begin
              if (n_q < 3'd6) begin
                read_en     = SRC_R + {1'b0, n_q};
                write_en[3] = 1'b1;
                case (opcode_q)
                  OP_ADD:  alu_op = 2'b01;
                  OP_SUB:  alu_op = 2'b10;
                  default: alu_op = 2'b00;
                endcase
              end
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          case (opcode_q)
            OP_LDAC: begin
              read_en     = SRC_DM;
              write_en[3] = 1'b1;
            end
            OP_JPNZ: begin
              if (!z_flag) begin
                read_en     = SRC_IM;
                write_en[0] = 1'b1;
              end else begin
                pc_inc = 1'b1;
              end
            end
            OP_LDIM: begin
              read_en     = SRC_IM;
              write_en[1] = 1'b1;
              pc_inc      = 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  logic unused_src_pc;
  assign unused_src_pc = ^SRC_PC;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a per-instruction cycle-table model.
module tb_control_sequencer;

  localparam bit HALT_ON_ILLEGAL = 1'b0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir = '0;
  logic        z_flag = 1'b0;
  logic [3:0]  read_en;
  logic [10:0] write_en;
  logic [1:0]  alu_op;
  logic        pc_inc;
  logic        halted;
  logic [18:0] dut_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  control_sequencer #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) dut (
    .clock    (clock),
    .reset    (reset),
    .ir       (ir),
    .z_flag   (z_flag),
    .read_en  (read_en),
    .write_en (write_en),
    .alu_op   (alu_op),
    .pc_inc   (pc_inc),
    .halted   (halted)
  );

  always #5 clock = ~clock;

  assign dut_out = {halted, pc_inc, alu_op, write_en, read_en};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] pack(input int rd, input int we_bit, input int alu,
                                       input bit pc, input bit h);
    logic [10:0] we;
    we = (we_bit < 0) ? 11'd0 : (11'd1 << we_bit);
    return {h, pc, 2'(alu), we, 4'(rd)};
  endfunction

  function automatic int latency(input logic [3:0] op);
    case (op)
      4'h1, 4'h7, 4'h8:             return 5;
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6: return 4;
      default:                      return 3;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = FETCH1) of an instruction.
  function automatic logic [18:0] model(input logic [15:0] instr, input int k, input logic z);
    int op;
    int n;
    op = int'(instr[15:12]);
    n  = int'(instr[2:0]);
    if (k == 1) return pack(13, 2, 0, 1'b1, 1'b0);
    if (k == 3) begin
      case (op)
        2: return pack(5, 10, 0, 1'b0, 1'b0);
        3: return pack(5, (n < 6) ? 4 + n : -1, 0, 1'b0, 1'b0);
        4, 5, 6: return (n < 6) ? pack(6 + n, 3, op - 4, 1'b0, 1'b0) : '0;
        default: return '0;
      endcase
    end
    if (k == 4) begin
      case (op)
        1: return pack(12, 3, 0, 1'b0, 1'b0);
        7: return z ? pack(0, -1, 0, 1'b1, 1'b0) : pack(13, 0, 0, 1'b0, 1'b0);
        8: return pack(13, 1, 0, 1'b1, 1'b0);
        default: return '0;
      endcase
    end
    return '0;
  endfunction

  // zmode: 0/1 forces z_flag, 2 randomizes it; abort_at asserts reset during that cycle.
  task automatic run_instr(input logic [15:0] instr, input int zmode, input int abort_at,
                           input string tag);
    int lat;
    lat = latency(instr[15:12]);
    for (int k = 0; k < lat; k++) begin
      ir     = (k == 2) ? instr : 16'($urandom);
      z_flag = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clock);
        check($sformatf("%s_abort", tag), 32'(dut_out), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        return;
      end
      @(negedge clock);
      check($sformatf("%s_c%0d", tag, k), 32'(dut_out), 32'(model(instr, k, z_flag)));
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [15:0] instr;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("reset", 32'(dut_out), 32'd0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;

    run_instr(16'h8000, 2, -1, "ldim");
    run_instr(16'h5003, 2, -1, "add_r3");
    run_instr(16'h7000, 0, -1, "jpnz_z0");
    run_instr(16'h7000, 1, -1, "jpnz_z1");
    run_instr(16'h3007, 2, -1, "mvac_n7");
    run_instr(16'h2000, 2, -1, "stac");
    run_instr(16'h4006, 2, -1, "movr_n6");
    run_instr(16'h1000, 2, -1, "ldac");
    run_instr(16'h0000, 2, -1, "nop");
    run_instr(16'h9000, 2, -1, "illegal");

    for (int i = 0; i < 250; i++) begin
      instr = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(instr, 2, -1, $sformatf("rnd%0d_%04h", i, instr));
    end

    run_instr(16'h1000, 2, 3, "ldac_rst");
    run_instr(16'h1000, 2, -1, "ldac_after_rst");
    run_instr(16'h5001, 2, 3, "add_rst");
    run_instr(16'h6002, 2, -1, "sub_after_rst");
    run_instr(16'h7000, 0, 4, "jpnz_rst");
    run_instr(16'h0000, 2, -1, "nop_after_rst");

    run_instr(16'hF000, 2, -1, "halt");
    for (int i = 0; i < 20; i++) begin
      ir     = 16'($urandom);
      z_flag = 1'($urandom);
      @(negedge clock);
      check($sformatf("halted%0d", i), 32'(dut_out), 32'h40000);
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(negedge clock);
    check("halt_reset", 32'(dut_out), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    run_instr(16'h2000, 2, -1, "stac_after_halt");
    run_instr(16'h8000, 2, -1, "ldim_after_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator processor.
- Sits directly upstream of the shared bus multiplexer. Drives its 4-bit source select `read_en`.
- Also drives the one-hot destination load strobes, the ALU op and the PC increment.
- Consumes the instruction register contents and the ALU zero flag.

Parameters:
- HALT_ON_ILLEGAL, 0, 1 = undefined opcode enters HALT; 0 = undefined opcode executes as NOP.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- ir  input  16  instruction register contents.
  - opcode = ir[15:12].
  - register field n = ir[2:0]: 0=R, 1..5=R1..R5.
- z_flag  input  1  ALU zero flag; sampled only in EXEC2 of JPNZ.
- read_en  output  4  bus source select.
  - 0=none, 1=PC, 2=DAR, 4=IR, 5=AC, 6=R, 7..11=R1..R5, 12=DM, 13=IM.
- write_en  output  11  one-hot load strobes, sampled by destinations on the next edge.
  - bit0 PC, bit1 DAR, bit2 IR, bit3 AC, bit4 R, bit5..9 R1..R5, bit10 DM write.
- alu_op  output  2  00 pass bus to AC, 01 AC+bus, 10 AC-bus, 11 reserved.
- pc_inc  output  1  PC += 1 at the next edge.
- halted  output  1  high while in HALT.

Behaviour:
- One clock `clock`. Reset `reset` is synchronous and active-high.
- Reset forces state FETCH1. All outputs are 0 during and after reset until the FSM advances. Reset mid-instruction aborts it; no strobes are issued in the reset cycle.
- Outputs are Moore-decoded from the state register plus the latched opcode/n.
  - Opcode and n are latched in DECODE.
  - At most one `write_en` bit is high per cycle.
  - Every output not listed for a state is 0.
- FETCH1: IM is addressed by PC (1-cycle read latency). No bus activity. Goes to FETCH2.
- FETCH2: read_en=13, write_en[2]=1, pc_inc=1. Goes to DECODE.
- DECODE: latches opcode and n. No strobes. Dispatches as follows:
  - 0x0 NOP: back to FETCH1 (3 cycles total).
  - 0xF HALT: to HALT.
  - 0x9..0xE undefined: NOP, or HALT if HALT_ON_ILLEGAL=1.
  - all others: to EXEC1.
- Execute sequences by opcode:
  - 0x1 LDAC: EXEC1 waits (DM addressed by DAR). EXEC2: read_en=12, write_en[3], alu_op=00.
  - 0x2 STAC: EXEC1: read_en=5, write_en[10].
  - 0x3 MVAC: EXEC1: read_en=5, write_en[4+n] for n=0..5. n=6/7 issues no strobe.
  - 0x4 MOVR: EXEC1: read_en=6+n, write_en[3], alu_op=00. n=6/7 issues no strobe and read_en=0.
  - 0x5 ADD / 0x6 SUB: as MOVR, with alu_op=01 / 10.
  - 0x7 JPNZ: EXEC1 waits (IM addressed by PC). EXEC2: if z_flag=0, read_en=13 and write_en[0]; else pc_inc=1 to skip the operand word.
  - 0x8 LDIM: EXEC1 waits. EXEC2: read_en=13, write_en[1], pc_inc=1.
- After the last EXEC state the FSM returns to FETCH1.
- Instruction latencies:
  - NOP: 3 cycles.
  - STAC, MVAC, MOVR, ADD, SUB: 4 cycles.
  - LDAC, LDIM, JPNZ: 5 cycles.
- HALT: halted=1, all strobes 0. Exits only on reset.
- `ir` changes after DECODE do not affect the executing instruction, because the latched copy is used.

Test Plan:
- Reset held 2 cycles, then released -> cycle 1 FETCH1 with all outputs 0. Cycle 2: read_en=13, write_en=0x004, pc_inc=1.
- ir=0x8000 (LDIM), then 0x5003 (ADD R3) -> LDIM EXEC2: read_en=13, write_en=0x002, pc_inc=1.
  - ADD EXEC1: read_en=9, write_en=0x008, alu_op=01.
  - The next instruction's FETCH1 starts 9 cycles after the first fetch.
- ir=0x7000, z_flag=0 -> EXEC2: read_en=13, write_en=0x001, pc_inc=0.
- ir=0x7000, z_flag=1 -> EXEC2: read_en=0, write_en=0, pc_inc=1.
- ir=0x3007 (MVAC n=7) and ir=0x2000 (STAC) -> MVAC issues no strobe. STAC EXEC1: read_en=5, write_en=0x400.
- ir=0xF000 -> halted=1 and stays 1 for 20 cycles with all strobes 0. Assert reset in the middle of a LDAC EXEC1 -> next cycle is FETCH1 with no AC write.
